multicycle_ctrl_fsm: RTL and testbench

- Self-contained multi-cycle MIPS controller: owns its state register, sequences IF/ID/EX/MEM/WB and generates all datapath control flags from that state.
- Generalised over the previous controller:
  - variable-latency memory handshake with a wait-cycle timeout;
  - bne, jal and addi in addition to R-type, lw, sw, beq and j;
  - illegal-opcode trap;
  - retired-instruction counter;
  - parametrised ALU-op and counter widths.
- Sits between the instruction register and the datapath muxes, register file and memory port.

---
 rtl/multicycle_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS controller: IF/ID/EX/MEM/WB sequencing,
// memory wait timeout, illegal-opcode trap and retire counter.
module multicycle_ctrl_fsm #(
  parameter int ALU_OP_W = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst_flag,
  output logic                alu_src_flag,
  output logic                mem_to_reg_flag,
  output logic                reg_write_flag,
  output logic                mem_read_flag,
  output logic                mem_write_flag,
  output logic                branch_flag,
  output logic                branch_ne_flag,
  output logic                jump_flag,
  output logic                link_flag,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired,
  output logic                illegal,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // one spare count above WAIT_MAX so the trap cycle cannot wrap
  localparam int WW = $clog2(WAIT_MAX + 2);

  localparam logic [ALU_OP_W-1:0] A_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] A_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] A_FN  = ALU_OP_W'(2);

  state_t        cur;
  state_t        nxt;
  logic [WW-1:0] wcnt;
  logic          is_r, is_lw, is_sw, is_beq;
  logic          is_bne, is_j, is_jal, is_addi;
  logic          legal;
  logic          in_mem;
  logic          wait_hit;
  logic          trap_ill;
  logic          trap_to;

  assign is_r    = opcode == OP_R;
  assign is_lw   = opcode == OP_LW;
  assign is_sw   = opcode == OP_SW;
  assign is_beq  = opcode == OP_BEQ;
  assign is_bne  = opcode == OP_BNE;
  assign is_j    = opcode == OP_J;
  assign is_jal  = opcode == OP_JAL;
  assign is_addi = opcode == OP_ADDI;
  assign legal   = is_r | is_lw | is_sw | is_beq
                 | is_bne | is_j | is_jal | is_addi;

  assign in_mem   = (cur == S_IF) || (cur == S_MEM);
  assign wait_hit = (WAIT_MAX != 0) && in_mem && !mem_ready
                 && (wcnt == WW'(WAIT_MAX));
  assign state    = cur;

  always_comb begin
    nxt             = cur;
    trap_ill        = 1'b0;
    trap_to         = 1'b0;
    pc_write        = 1'b0;
    ir_write        = 1'b0;
    reg_dst_flag    = 1'b0;
    alu_src_flag    = 1'b0;
    mem_to_reg_flag = 1'b0;
    reg_write_flag  = 1'b0;
    mem_read_flag   = 1'b0;
    mem_write_flag  = 1'b0;
    branch_flag     = 1'b0;
    branch_ne_flag  = 1'b0;
    jump_flag       = 1'b0;
    link_flag       = 1'b0;
    alu_op          = A_ADD;
    instr_done      = 1'b0;
    unique case (cur)
      S_IF: begin
        mem_read_flag = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_ID;
        end else if (wait_hit) begin
          trap_to = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_ID: begin
        if (!legal) begin
          trap_ill = 1'b1;
          nxt      = S_TRAP;
        end else if (is_j) begin
          jump_flag  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          nxt        = S_IF;
        end else if (is_jal) begin
          nxt = S_WB;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        unique case (1'b1)
          is_r: begin
            alu_op = A_FN;
            nxt    = S_WB;
          end
          is_addi: begin
            alu_src_flag = 1'b1;
            nxt          = S_WB;
          end
          is_lw, is_sw: begin
            alu_src_flag = 1'b1;
            nxt          = S_MEM;
          end
          is_beq: begin
            branch_flag = 1'b1;
            alu_op      = A_SUB;
            instr_done  = 1'b1;
            nxt         = S_IF;
          end
          is_bne: begin
            branch_ne_flag = 1'b1;
            alu_op         = A_SUB;
            instr_done     = 1'b1;
            nxt            = S_IF;
          end
          default: nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_read_flag  = is_lw;
        mem_write_flag = is_sw;
        if (mem_ready) begin
          instr_done = is_sw;
          nxt        = is_sw ? S_IF : S_WB;
        end else if (wait_hit) begin
          trap_to = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_WB: begin
        reg_write_flag  = 1'b1;
        instr_done      = 1'b1;
        reg_dst_flag    = is_r;
        mem_to_reg_flag = is_lw;
        link_flag       = is_jal;
        jump_flag       = is_jal;
        pc_write        = is_jal;
        nxt             = S_IF;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
    if (rst) begin
      pc_write        = 1'b0;
      ir_write        = 1'b0;
      reg_dst_flag    = 1'b0;
      alu_src_flag    = 1'b0;
      mem_to_reg_flag = 1'b0;
      reg_write_flag  = 1'b0;
      mem_read_flag   = 1'b0;
      mem_write_flag  = 1'b0;
      branch_flag     = 1'b0;
      branch_ne_flag  = 1'b0;
      jump_flag       = 1'b0;
      link_flag       = 1'b0;
      alu_op          = A_ADD;
      instr_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_IF;
      wcnt    <= '0;
      retired <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cur <= nxt;
      if (instr_done)
        retired <= retired + 1'b1;
      if (mem_ready || ((nxt != cur) &&
          ((nxt == S_IF) || (nxt == S_MEM))))
        wcnt <= '0;
      else if (in_mem && (WAIT_MAX != 0))
        wcnt <= wcnt + 1'b1;
      if (trap_ill)
        illegal <= 1'b1;
      if (trap_to)
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (WAIT_MAX=4, CNT_W=2).
// Inputs change on negedge; outputs are checked 1ns later.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b100011;
  logic [5:0] funct = 6'b100000;
  logic       mem_ready = 1'b1;
  logic [2:0] state;
  logic       pc_write, ir_write, reg_dst_flag, alu_src_flag;
  logic       mem_to_reg_flag, reg_write_flag, mem_read_flag;
  logic       mem_write_flag, branch_flag, branch_ne_flag;
  logic       jump_flag, link_flag, instr_done;
  logic [1:0] alu_op;
  logic [1:0] retired;
  logic       illegal, timeout;
  logic [12:0] fl;

  int errs = 0;
  int checks = 0;

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  localparam logic [12:0] F_PC = 13'h1000;
  localparam logic [12:0] F_IR = 13'h0800;
  localparam logic [12:0] F_RD = 13'h0400;
  localparam logic [12:0] F_AS = 13'h0200;
  localparam logic [12:0] F_MR = 13'h0100;
  localparam logic [12:0] F_RW = 13'h0080;
  localparam logic [12:0] F_RM = 13'h0040;
  localparam logic [12:0] F_WM = 13'h0020;
  localparam logic [12:0] F_BR = 13'h0010;
  localparam logic [12:0] F_BN = 13'h0008;
  localparam logic [12:0] F_JP = 13'h0004;
  localparam logic [12:0] F_LK = 13'h0002;
  localparam logic [12:0] F_DN = 13'h0001;
  localparam logic [12:0] F_IF = F_PC | F_IR | F_RM;

  assign fl = {pc_write, ir_write, reg_dst_flag, alu_src_flag,
               mem_to_reg_flag, reg_write_flag, mem_read_flag,
               mem_write_flag, branch_flag, branch_ne_flag,
               jump_flag, link_flag, instr_done};

  multicycle_ctrl_fsm #(
    .ALU_OP_W(2),
    .WAIT_MAX(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .funct(funct),
    .mem_ready(mem_ready),
    .state(state),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .reg_dst_flag(reg_dst_flag),
    .alu_src_flag(alu_src_flag),
    .mem_to_reg_flag(mem_to_reg_flag),
    .reg_write_flag(reg_write_flag),
    .mem_read_flag(mem_read_flag),
    .mem_write_flag(mem_write_flag),
    .branch_flag(branch_flag),
    .branch_ne_flag(branch_ne_flag),
    .jump_flag(jump_flag),
    .link_flag(link_flag),
    .alu_op(alu_op),
    .instr_done(instr_done),
    .retired(retired),
    .illegal(illegal),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic [5:0] op,
                      input logic rdy);
    @(negedge clk);
    rst = r;
    opcode = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic expect_cyc(input string tag,
                            input logic [2:0] st,
                            input logic [12:0] f,
                            input logic [1:0] aop);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".flags"}, 32'(fl), 32'(f));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(aop));
  endtask

  initial begin
    step(1, LW, 1);
    chk("rst.flags", 32'(fl), 32'h0);
    step(0, LW, 1);
    chk("rst.retired", 32'(retired), 0);
    chk("rst.illegal", 32'(illegal), 0);
    chk("rst.timeout", 32'(timeout), 0);
    expect_cyc("lw.if", 3'd0, F_IF, 2'd0);
    step(0, LW, 1);
    expect_cyc("lw.id", 3'd1, 13'h0, 2'd0);
    step(0, LW, 1);
    expect_cyc("lw.ex", 3'd2, F_AS, 2'd0);
    step(0, LW, 1);
    expect_cyc("lw.mem", 3'd3, F_RM, 2'd0);
    step(0, LW, 1);
    expect_cyc("lw.wb", 3'd4, F_RW | F_MR | F_DN, 2'd0);

    step(0, R, 1);
    chk("lw.retired", 32'(retired), 1);
    expect_cyc("r.if", 3'd0, F_IF, 2'd0);
    step(0, R, 1);
    expect_cyc("r.id", 3'd1, 13'h0, 2'd0);
    step(0, R, 1);
    expect_cyc("r.ex", 3'd2, 13'h0, 2'd2);
    step(0, R, 1);
    expect_cyc("r.wb", 3'd4, F_RW | F_RD | F_DN, 2'd0);

    step(0, BNE, 1);
    chk("r.retired", 32'(retired), 2);
    expect_cyc("bne.if", 3'd0, F_IF, 2'd0);
    step(0, BNE, 1);
    expect_cyc("bne.id", 3'd1, 13'h0, 2'd0);
    step(0, BNE, 1);
    expect_cyc("bne.ex", 3'd2, F_BN | F_DN, 2'd1);

    step(0, SW, 1);
    chk("bne.retired", 32'(retired), 3);
    expect_cyc("sw.if", 3'd0, F_IF, 2'd0);
    step(0, SW, 1);
    step(0, SW, 1);
    expect_cyc("sw.ex", 3'd2, F_AS, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, SW, 0);
      expect_cyc("sw.wait", 3'd3, F_WM, 2'd0);
    end
    step(0, SW, 1);
    expect_cyc("sw.rdy", 3'd3, F_WM | F_DN, 2'd0);

    step(0, R, 0);
    chk("sw.timeout", 32'(timeout), 0);
    chk("sw.wrap", 32'(retired), 0);
    for (int i = 0; i < 5; i++) begin
      expect_cyc("to.if", 3'd0, F_RM, 2'd0);
      step(0, R, 0);
    end
    expect_cyc("to.trap", 3'd5, 13'h0, 2'd0);
    chk("to.timeout", 32'(timeout), 1);
    step(1, R, 1);
    chk("to.rstflags", 32'(fl), 0);
    step(0, BAD, 0);
    chk("to.rststate", 32'(state), 0);
    chk("to.rsttimeout", 32'(timeout), 0);

    for (int i = 0; i < 3; i++)
      step(0, BAD, 0);
    step(0, BAD, 1);
    expect_cyc("edge.if", 3'd0, F_IF, 2'd0);
    step(0, BAD, 0);
    expect_cyc("ill.id", 3'd1, 13'h0, 2'd0);
    chk("edge.timeout", 32'(timeout), 0);
    step(0, BAD, 1);
    expect_cyc("ill.trap", 3'd5, 13'h0, 2'd0);
    chk("ill.illegal", 32'(illegal), 1);
    step(0, BAD, 0);
    step(0, LW, 1);
    expect_cyc("ill.hold", 3'd5, 13'h0, 2'd0);
    chk("ill.retired", 32'(retired), 0);
    chk("ill.sticky", 32'(illegal), 1);

    step(1, JAL, 1);
    step(0, JAL, 1);
    chk("ill.rstill", 32'(illegal), 0);
    expect_cyc("jal.if", 3'd0, F_IF, 2'd0);
    step(0, JAL, 1);
    expect_cyc("jal.id", 3'd1, 13'h0, 2'd0);
    step(0, JAL, 1);
    expect_cyc("jal.wb", 3'd4,
               F_RW | F_LK | F_JP | F_PC | F_DN, 2'd0);

    step(0, J, 1);
    chk("jal.retired", 32'(retired), 1);
    expect_cyc("j.if", 3'd0, F_IF, 2'd0);
    step(0, J, 1);
    expect_cyc("j.id", 3'd1, F_JP | F_PC | F_DN, 2'd0);

    step(0, ADI, 1);
    chk("j.retired", 32'(retired), 2);
    expect_cyc("addi.if", 3'd0, F_IF, 2'd0);
    step(0, ADI, 1);
    step(0, ADI, 1);
    expect_cyc("addi.ex", 3'd2, F_AS, 2'd0);
    step(0, ADI, 1);
    expect_cyc("addi.wb", 3'd4, F_RW | F_DN, 2'd0);

    step(0, BEQ, 1);
    chk("addi.retired", 32'(retired), 3);
    step(0, BEQ, 1);
    step(0, BEQ, 1);
    expect_cyc("beq.ex", 3'd2, F_BR | F_DN, 2'd1);

    step(0, J, 1);
    chk("beq.wrap", 32'(retired), 0);
    step(0, J, 1);
    expect_cyc("j2.id", 3'd1, F_JP | F_PC | F_DN, 2'd0);
    step(0, J, 1);
    chk("wrap5.retired", 32'(retired), 1);
    chk("wrap5.state", 32'(state), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
